seg_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the 16-bit ripple-carry adder. It processes WIDTH-bit operands SEG bits per clock through a registered carry, so wide adders use a short carry chain. It reports unsigned carry and signed overflow and sits behind valid/ready handshakes on both sides. It is the arithmetic core used by the datapath blocks built on top of it.

---
 rtl/seg_adder_if.sv | 31 +++
 rtl/seg_adder.sv | 137 +++++++++++++
 tb/tb_seg_adder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_adder_if
// Brief    : Operand/result handshake bundle for seg_adder.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             overflow;

  modport slave (
    input  in_valid, in1, in2, sub, out_ready,
    output in_ready, out_valid, out, carry, overflow
  );

  modport master (
    output in_valid, in1, in2, sub, out_ready,
    input  in_ready, out_valid, out, carry, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seg_adder.sv
`default_nettype none
// ============================================================================
// Module   : seg_adder
// Brief    : Multi-cycle adder/subtractor summing SEG bits per clock through a
//            registered carry. Define SEG_ADDER_SAT_EN to saturate on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module seg_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic       clk,
  input  logic       reset,
  seg_adder_if.slave bus
);

  localparam int              NSEG     = WIDTH / SEG;
  localparam int              IDXW     = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [SEG-1:0]   w_a_seg;
  logic [SEG-1:0]   w_b_seg;
  logic [SEG:0]     w_seg_sum;
  logic             w_c_msb;
  logic             w_ovf;

`ifdef SEG_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Segment slice of the current step and its short carry chain.
  always_comb begin
    w_a_seg   = a_q[int'(idx_q)*SEG +: SEG];
    w_b_seg   = b_q[int'(idx_q)*SEG +: SEG];
    w_seg_sum = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG{1'b0}}, cin_q};
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
    w_c_msb   = w_a_seg[SEG-1] ^ w_b_seg[SEG-1] ^ w_seg_sum[SEG-1];
    w_ovf     = w_c_msb ^ w_seg_sum[SEG];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    idx_d   = idx_q;
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1, the +1 riding in as the initial carry.
          a_d     = bus.in1;
          b_d     = bus.sub ? ~bus.in2 : bus.in2;
          cin_d   = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        out_d[int'(idx_q)*SEG +: SEG] = w_seg_sum[SEG-1:0];
        cin_d = w_seg_sum[SEG];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          carry_d = w_seg_sum[SEG];
          ovf_d   = w_ovf;
          state_d = DONE;
`ifdef SEG_ADDER_SAT_EN
          if (w_ovf) begin
            out_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
`endif
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_adder
// Brief    : Directed WIDTH=16/SEG=4 checks plus a randomized sweep of WIDTH/SEG
//            instances compared against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_adder;

  localparam int NCFG = 14;
  localparam int NOPS = 1000;

  typedef struct packed {
    logic [63:0] o;
    logic        c;
    logic        v;
  } res_t;

  logic        clk;
  logic        d_rst;
  logic        sweep_rst;
  int unsigned cyc;
  int          n_checks;
  int          n_err;
  logic [NCFG-1:0] sweep_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference result from unsigned/signed arithmetic on the whole word.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input int w);
    res_t        r;
    logic [63:0] m;
    logic [63:0] ua;
    logic [63:0] ub;
    logic        sa, sb, so;
    m  = (64'd1 << w) - 64'd1;
    ua = a & m;
    ub = b & m;
    if (s) begin
      r.c = (ua >= ub);
      r.o = (ua - ub) & m;
    end else begin
      r.c = ((ua + ub) >> w) != 64'd0;
      r.o = (ua + ub) & m;
    end
    sa = ua[w-1];
    sb = ub[w-1];
    so = r.o[w-1];
    r.v = s ? ((sa != sb) && (so != sa)) : ((sa == sb) && (so != sa));
`ifdef SEG_ADDER_SAT_EN
    if (r.v) r.o = sa ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
    return r;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w-1);
      3:       return (64'd1 << (w-1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  function automatic int cfg_w(input int k);
    return (k < 4) ? 8 : (k < 9) ? 16 : 32;
  endfunction

  function automatic int cfg_s(input int k);
    return 1 << ((k < 4) ? k : (k < 9) ? k - 4 : k - 9);
  endfunction

  // ---------------- directed instance (WIDTH=16, SEG=4) ----------------
  seg_adder_if #(.WIDTH(16)) d_if ();

  seg_adder #(.WIDTH(16), .SEG(4)) u_dut (
    .clk   (clk),
    .reset (d_rst),
    .bus   (d_if)
  );

  task automatic chk_idle_regs(input string nm);
    chk({nm, " in_ready"},  64'(d_if.in_ready),  64'd1);
    chk({nm, " out_valid"}, 64'(d_if.out_valid), 64'd0);
    chk({nm, " out"},       64'(d_if.out),       64'd0);
    chk({nm, " carry"},     64'(d_if.carry),     64'd0);
    chk({nm, " overflow"},  64'(d_if.overflow),  64'd0);
  endtask

  // Called at posedge+1 with the block idle; returns at posedge+1, idle again.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold, input logic [15:0] eo,
                        input logic ec, input logic ev);
    int t;
    chk({nm, " in_ready"}, 64'(d_if.in_ready), 64'd1);
    d_if.in1 = a; d_if.in2 = b; d_if.sub = s; d_if.in_valid = 1'b1;
    d_if.out_ready = (hold == 0);
    @(posedge clk); #1;
    d_if.in_valid = 1'b0; d_if.in1 = ~a; d_if.in2 = ~b; d_if.sub = ~s;
    t = 0;
    while (!d_if.out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, " latency"},  64'(t),             64'd4);
    chk({nm, " out"},      64'(d_if.out),      64'(eo));
    chk({nm, " carry"},    64'(d_if.carry),    64'(ec));
    chk({nm, " overflow"}, 64'(d_if.overflow), 64'(ev));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold out_valid"}, 64'(d_if.out_valid), 64'd1);
      chk({nm, " hold in_ready"},  64'(d_if.in_ready),  64'd0);
      chk({nm, " hold out"},       64'(d_if.out),       64'(eo));
      chk({nm, " hold flags"},     64'({d_if.carry, d_if.overflow}), 64'({ec, ev}));
    end
    d_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " post out_valid"}, 64'(d_if.out_valid), 64'd0);
    chk({nm, " post in_ready"},  64'(d_if.in_ready),  64'd1);
  endtask

  // ---------------- randomized sweep instances ----------------
  for (genvar k = 0; k < NCFG; k++) begin : g_sweep
    localparam int W = cfg_w(k);
    localparam int S = cfg_s(k);
    localparam int N = W / S;

    seg_adder_if #(.WIDTH(W)) s_if ();

    seg_adder #(.WIDTH(W), .SEG(S)) u_dut (
      .clk   (clk),
      .reset (sweep_rst),
      .bus   (s_if)
    );

    string       tag;
    bit          r_done;
    bit          r_busy;
    bit          exp_v;
    int unsigned r_acc;
    res_t        r_exp;

    initial tag = $sformatf("W%0d/S%0d", W, S);
    initial r_busy = 1'b0;
    assign sweep_done[k] = r_done;

    always @(posedge clk) begin
      #1;
      s_if.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin : p_drv
      int t;
      r_done = 1'b0;
      s_if.in_valid = 1'b0; s_if.in1 = '0; s_if.in2 = '0; s_if.sub = 1'b0;
      wait (sweep_rst == 1'b0);
      @(posedge clk); #1;
      for (int n = 0; n < NOPS; n++) begin
        s_if.in1 = W'(pick(W)); s_if.in2 = W'(pick(W));
        s_if.sub = 1'($urandom_range(0, 1)); s_if.in_valid = 1'b1;
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        s_if.in1 = W'($urandom); s_if.in2 = W'($urandom); s_if.sub = 1'($urandom_range(0, 1));
        t = 0;
        while (!s_if.in_ready && t < 500) begin
          @(posedge clk); #1;
          t++;
        end
        if (!s_if.in_ready) begin
          chk({tag, " op timeout in_ready"}, 64'(s_if.in_ready), 64'd1);
          break;
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      r_done = 1'b1;
    end

    // Compare process: result due exactly N edges after the accept edge.
    always @(negedge clk) begin
      if (!sweep_rst) begin
        exp_v = r_busy && (cyc >= r_acc + N);
        chk({tag, " out_valid"}, 64'(s_if.out_valid), 64'(exp_v));
        chk({tag, " in_ready"},  64'(s_if.in_ready),  64'(!r_busy));
        if (exp_v && s_if.out_valid) begin
          chk({tag, " out"},      64'(s_if.out),      r_exp.o);
          chk({tag, " carry"},    64'(s_if.carry),    64'(r_exp.c));
          chk({tag, " overflow"}, 64'(s_if.overflow), 64'(r_exp.v));
        end
        if (s_if.out_valid && s_if.out_ready) r_busy = 1'b0;
        if (s_if.in_valid && s_if.in_ready) begin
          r_exp  = model(64'(s_if.in1), 64'(s_if.in2), s_if.sub, W);
          r_acc  = cyc + 1;
          r_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : p_main
    res_t r;
    int   t;
    n_checks = 0;
    n_err    = 0;
    d_rst = 1'b1; sweep_rst = 1'b1;
    d_if.in_valid = 1'b0; d_if.in1 = '0; d_if.in2 = '0; d_if.sub = 1'b0; d_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_regs("reset");
    d_rst = 1'b0; sweep_rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_regs("after reset");

    r = model(64'h7FFF, 64'h0001, 1'b0, 16);
`ifdef SEG_ADDER_SAT_EN
    chk("model 7FFF+1 out", r.o, 64'h7FFF);
`else
    chk("model 7FFF+1 out", r.o, 64'h8000);
`endif
    chk("model 7FFF+1 flags", 64'({r.c, r.v}), 64'b01);
    r = model(64'h0005, 64'h0007, 1'b1, 16);
    chk("model 5-7 out", r.o, 64'hFFFE);
    chk("model 5-7 flags", 64'({r.c, r.v}), 64'b00);
    r = model(64'h80, 64'h01, 1'b1, 8);
`ifdef SEG_ADDER_SAT_EN
    chk("model 80-1 w8 out", r.o, 64'h80);
`else
    chk("model 80-1 w8 out", r.o, 64'h7F);
`endif
    chk("model 80-1 w8 flags", 64'({r.c, r.v}), 64'b11);

    run_op("FFFF+1", 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
`ifdef SEG_ADDER_SAT_EN
    run_op("7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b0, 1'b1);
`else
    run_op("7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
`endif
    run_op("5-7", 16'h0005, 16'h0007, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    run_op("backpressure", 16'h1111, 16'h2222, 1'b0, 10, 16'h3333, 1'b0, 1'b0);
    // Issued straight after returning to IDLE: accept one cycle later.
`ifdef SEG_ADDER_SAT_EN
    run_op("8000-1", 16'h8000, 16'h0001, 1'b1, 0, 16'h8000, 1'b1, 1'b1);
`else
    run_op("8000-1", 16'h8000, 16'h0001, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Abort during the second RUN cycle; flags from 8000-1 are still set.
    d_if.in1 = 16'h1111; d_if.in2 = 16'h2222; d_if.sub = 1'b0; d_if.in_valid = 1'b1;
    @(posedge clk); #1;
    d_if.in_valid = 1'b0;
    @(posedge clk); #2;
    d_rst = 1'b1;
    #1;
    chk_idle_regs("abort");
    @(posedge clk); #1;
    d_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort no out_valid", 64'(d_if.out_valid), 64'd0);
    end
    run_op("1234+4321", 16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);

    t = 0;
    while (sweep_done != {NCFG{1'b1}} && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep complete", 64'(sweep_done), 64'({NCFG{1'b1}}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
